// File: rtl/frame_buffer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | frame_buffer_pkg : frame-buffer geometry, FSM states, DDR address pack   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package frame_buffer_pkg;

   localparam int X_WID           = 12;
   localparam int Y_WID           = 12;
   localparam int BURST_LEN       = 32;
   localparam int BYTES_PER_BURST = 2048;
   localparam int BIDX_WID        = X_WID - 11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ADDR  = 2'd1,
      ST_DATA  = 2'd2,
      ST_FLUSH = 2'd3
   } rd_state_t;

   // {5'b0, frame, y, burst_idx, 11'b0}: one 2 KiB burst per slot
   function automatic logic [31:0] pack_addr(
      input logic [2:0]          frame,
      input logic [Y_WID-1:0]    y,
      input logic [BIDX_WID-1:0] burst_idx
   );
      return 32'({frame, y, burst_idx, 11'b0});
   endfunction

endpackage
`default_nettype wire

// File: rtl/rd_beat_downsizer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rd_beat_downsizer : 512-bit beat holding register, 32-bit word out       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rd_beat_downsizer (
   input  logic         axi_clk,
   input  logic         rst,
   input  logic         in_load,
   input  logic [511:0] in_load_data,
   input  logic         in_pop,
   input  logic         in_flush,
   output logic         out_full,
   output logic         out_full_next,
   output logic         out_last_word,
   output logic [31:0]  out_word
);

   logic [511:0] hold_q, hold_d;
   logic         full_q, full_d;
   logic [3:0]   word_idx_q, word_idx_d;

   // A new beat wins over flush/pop so back-to-back beats leave no bubble
   always_comb begin
      hold_d     = hold_q;
      full_d     = full_q;
      word_idx_d = word_idx_q;
      if (in_load) begin
         hold_d     = in_load_data;
         full_d     = 1'b1;
         word_idx_d = 4'd0;
      end else if (in_flush) begin
         full_d = 1'b0;
      end else if (in_pop) begin
         word_idx_d = word_idx_q + 4'd1;
         if (word_idx_q == 4'd15) begin
            full_d = 1'b0;
         end
      end
   end

   always_ff @(posedge axi_clk or posedge rst) begin
      if (rst) begin
         hold_q     <= '0;
         full_q     <= 1'b0;
         word_idx_q <= 4'd0;
      end else begin
         hold_q     <= hold_d;
         full_q     <= full_d;
         word_idx_q <= word_idx_d;
      end
   end

   assign out_full      = full_q;
   assign out_full_next = full_d;
   assign out_last_word = (word_idx_q == 4'd15);
   assign out_word      = hold_q[{word_idx_q, 5'b0} +: 32];

endmodule
`default_nettype wire

// File: rtl/rd_address_decoder_512.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rd_address_decoder_512 : AXI4 line fetch master, 512-bit R to 32-bit px  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rd_address_decoder_512
   import frame_buffer_pkg::*;
(
   input  logic               axi_clk,
   input  logic               rst,
   input  logic [X_WID-1:0]   x_win,
   input  logic               in_req_valid,
   output logic               out_req_ready,
   input  logic [Y_WID-1:0]   in_req_y,
   input  logic [2:0]         in_req_frame,
   output logic               out_rd_avalid,
   input  logic               in_rd_aready,
   output logic [31:0]        out_rd_addr,
   output logic [7:0]         out_rd_len,
   input  logic               in_rd_valid,
   output logic               out_rd_ready,
   input  logic [511:0]       in_rd_data,
   input  logic               in_rd_last,
   output logic               out_pix_valid,
   input  logic               in_pix_ready,
   output logic [31:0]        out_pix_data,
   output logic               out_pix_last,
   output logic               out_err
);

   localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

   rd_state_t             state_q, state_d;
   logic [Y_WID-1:0]      y_q, y_d;
   logic [2:0]            frame_q, frame_d;
   logic [BIDX_WID-1:0]   burst_idx_q, burst_idx_d;
   logic [BIDX_WID:0]     nbursts_q, nbursts_d;
   logic [7:0]            beat_cnt_q, beat_cnt_d;
   logic [X_WID-3:0]      pix_cnt_q, pix_cnt_d;
   logic                  avalid_q, avalid_d;
   logic [31:0]           addr_q, addr_d;
   logic                  err_q, err_d;

   logic [X_WID-3:0]      x_words;
   logic                  words_left;
   logic                  hold_full, hold_full_next, hold_last_word;
   logic [31:0]           hold_word;
   logic                  pix_pop, hold_flush, rd_hs;
   logic [BIDX_WID:0]     burst_next;

   assign x_words       = x_win[X_WID-1:2];
   assign words_left    = (pix_cnt_q < x_words);
   assign out_pix_valid = hold_full && words_left;
   assign out_pix_data  = hold_word;
   assign out_pix_last  = out_pix_valid && (pix_cnt_q == x_words - 1'b1);
   assign pix_pop       = out_pix_valid && in_pix_ready;
   // Past the end of the line every word is dropped, so R never stalls
   assign hold_flush    = hold_full && (!words_left || (pix_pop && out_pix_last));
   assign out_rd_ready  = (state_q == ST_DATA) &&
                          (!hold_full || (pix_pop && hold_last_word) || hold_flush);
   assign rd_hs         = in_rd_valid && out_rd_ready;
   assign burst_next    = {1'b0, burst_idx_q} + 1'b1;

   assign out_req_ready = (state_q == ST_IDLE);
   assign out_rd_avalid = avalid_q;
   assign out_rd_addr   = addr_q;
   assign out_rd_len    = LAST_BEAT;
   assign out_err       = err_q;

   rd_beat_downsizer u_downsizer (
      .axi_clk       (axi_clk),
      .rst           (rst),
      .in_load       (rd_hs),
      .in_load_data  (in_rd_data),
      .in_pop        (pix_pop),
      .in_flush      (hold_flush),
      .out_full      (hold_full),
      .out_full_next (hold_full_next),
      .out_last_word (hold_last_word),
      .out_word      (hold_word)
   );

   always_comb begin
      state_d     = state_q;
      y_d         = y_q;
      frame_d     = frame_q;
      burst_idx_d = burst_idx_q;
      nbursts_d   = nbursts_q;
      beat_cnt_d  = beat_cnt_q;
      pix_cnt_d   = pix_cnt_q;
      avalid_d    = avalid_q;
      addr_d      = addr_q;
      err_d       = 1'b0;

      if (pix_pop) begin
         pix_cnt_d = pix_cnt_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (in_req_valid) begin
               y_d         = in_req_y;
               frame_d     = in_req_frame;
               burst_idx_d = '0;
               pix_cnt_d   = '0;
               nbursts_d   = {1'b0, x_win[X_WID-1:11]} +
                             {{BIDX_WID{1'b0}}, (x_win[10:0] != 11'd0)};
               addr_d      = pack_addr(in_req_frame, in_req_y, '0);
               avalid_d    = 1'b1;
               state_d     = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (in_rd_aready) begin
               avalid_d   = 1'b0;
               beat_cnt_d = 8'd0;
               state_d    = ST_DATA;
            end
         end
         ST_DATA: begin
            if (rd_hs) begin
               if (beat_cnt_q != 8'hFF) begin
                  beat_cnt_d = beat_cnt_q + 8'd1;
               end
               if (in_rd_last) begin
                  // Early last is still honoured as the burst end
                  err_d       = (beat_cnt_q != LAST_BEAT);
                  burst_idx_d = burst_next[BIDX_WID-1:0];
                  if (burst_next < nbursts_q) begin
                     addr_d   = pack_addr(frame_q, y_q, burst_next[BIDX_WID-1:0]);
                     avalid_d = 1'b1;
                     state_d  = ST_ADDR;
                  end else begin
                     state_d = ST_FLUSH;
                  end
               end else begin
                  err_d = (beat_cnt_q == LAST_BEAT);
               end
            end
         end
         ST_FLUSH: begin
            if (!hold_full_next) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge axi_clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         y_q         <= '0;
         frame_q     <= '0;
         burst_idx_q <= '0;
         nbursts_q   <= '0;
         beat_cnt_q  <= '0;
         pix_cnt_q   <= '0;
         avalid_q    <= 1'b0;
         addr_q      <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         y_q         <= y_d;
         frame_q     <= frame_d;
         burst_idx_q <= burst_idx_d;
         nbursts_q   <= nbursts_d;
         beat_cnt_q  <= beat_cnt_d;
         pix_cnt_q   <= pix_cnt_d;
         avalid_q    <= avalid_d;
         addr_q      <= addr_d;
         err_q       <= err_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rd_address_decoder_512.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rd_address_decoder_512 : directed bench for the line fetch master     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_rd_address_decoder_512;

   logic         axi_clk = 1'b0;
   logic         rst = 1'b1;
   logic [11:0]  x_win = 12'd0;
   logic         in_req_valid = 1'b0;
   logic         out_req_ready;
   logic [11:0]  in_req_y = 12'd0;
   logic [2:0]   in_req_frame = 3'd0;
   logic         out_rd_avalid;
   logic         in_rd_aready = 1'b0;
   logic [31:0]  out_rd_addr;
   logic [7:0]   out_rd_len;
   logic         in_rd_valid = 1'b0;
   logic         out_rd_ready;
   logic [511:0] in_rd_data = '0;
   logic         in_rd_last = 1'b0;
   logic         out_pix_valid;
   logic         in_pix_ready = 1'b0;
   logic [31:0]  out_pix_data;
   logic         out_pix_last;
   logic         out_err;

   int passed = 0;
   int failed = 0;
   int total  = 0;
   logic [31:0] ar0;

   always #5 axi_clk = ~axi_clk;

   rd_address_decoder_512 dut (
      .axi_clk       (axi_clk),
      .rst           (rst),
      .x_win         (x_win),
      .in_req_valid  (in_req_valid),
      .out_req_ready (out_req_ready),
      .in_req_y      (in_req_y),
      .in_req_frame  (in_req_frame),
      .out_rd_avalid (out_rd_avalid),
      .in_rd_aready  (in_rd_aready),
      .out_rd_addr   (out_rd_addr),
      .out_rd_len    (out_rd_len),
      .in_rd_valid   (in_rd_valid),
      .out_rd_ready  (out_rd_ready),
      .in_rd_data    (in_rd_data),
      .in_rd_last    (in_rd_last),
      .out_pix_valid (out_pix_valid),
      .in_pix_ready  (in_pix_ready),
      .out_pix_data  (out_pix_data),
      .out_pix_last  (out_pix_last),
      .out_err       (out_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else begin
         failed = failed + 1;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_ar(input logic [2:0] fr, input logic [11:0] y, input int b);
      return {5'b0, fr, y, b[0], 11'b0};
   endfunction

   // Memory content model: each 32-bit word is a scramble of its byte address
   function automatic logic [31:0] gen(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1234_5678;
   endfunction

   task automatic run_line(input logic [11:0] xw, input logic [11:0] y, input logic [2:0] fr,
                           input int ar_dly, input int last_at, input bit tog,
                           input int rst_at, input bit timing, output logic [31:0] first_ar);
      int exp_b, exp_w, cyc, words, beats, bursts, errs, ar_wait, beat, gaps;
      int first_rhs, first_pv, last_pop, rise;
      bit in_burst, done, bp_checked;
      logic [31:0] held, base, wa;
      exp_b = (int'(xw) + 2047) / 2048;
      exp_w = int'(xw) / 4;
      cyc = 0; words = 0; beats = 0; bursts = 0; errs = 0; ar_wait = 0; beat = 0; gaps = 0;
      first_rhs = -1; first_pv = -1; last_pop = -1; rise = -1;
      in_burst = 0; done = 0; bp_checked = 0; held = '0; base = '0; first_ar = '0;
      x_win = xw;
      @(negedge axi_clk);
      in_req_y = y; in_req_frame = fr; in_req_valid = 1'b1;
      chk("req_ready_idle", 32'(out_req_ready), 32'd1);
      @(negedge axi_clk);
      in_req_valid = 1'b0;
      while (!done && cyc < 5000) begin
         if (rst_at >= 0 && beats == rst_at) begin
            in_rd_valid = 1'b0; in_rd_last = 1'b0; in_rd_aready = 1'b0;
            rst = 1'b1;
            #1;
            chk("rst_avalid",    32'(out_rd_avalid), 32'd0);
            chk("rst_addr",      out_rd_addr,        32'd0);
            chk("rst_rd_ready",  32'(out_rd_ready),  32'd0);
            chk("rst_pix_valid", 32'(out_pix_valid), 32'd0);
            chk("rst_pix_last",  32'(out_pix_last),  32'd0);
            chk("rst_err",       32'(out_err),       32'd0);
            @(negedge axi_clk);
            rst = 1'b0;
            return;
         end
         in_pix_ready = tog ? cyc[0] : 1'b1;
         in_rd_aready = out_rd_avalid && !in_burst && (ar_wait >= ar_dly);
         in_rd_valid  = in_burst;
         in_rd_last   = in_burst && (beat == last_at);
         if (in_burst) begin
            for (int j = 0; j < 16; j++) begin
               in_rd_data[j*32 +: 32] = gen(base + 32'(beat*64 + j*4));
            end
         end
         #1;
         if (out_err) errs++;
         if (in_rd_valid && out_rd_ready) begin
            if (first_rhs < 0) first_rhs = cyc;
            beats++;
            if (in_rd_last) begin
               in_burst = 0;
               bursts++;
            end else begin
               beat++;
            end
         end
         if (out_rd_avalid && in_rd_aready) begin
            if (bursts == 0) first_ar = out_rd_addr;
            chk($sformatf("ar_addr_b%0d", bursts), out_rd_addr, exp_ar(fr, y, bursts));
            base = out_rd_addr;
            in_burst = 1; beat = 0; ar_wait = 0;
         end else if (out_rd_avalid) begin
            if (ar_wait == 0) held = out_rd_addr;
            else chk("ar_addr_stable", out_rd_addr, held);
            chk("no_r_before_ar", 32'(out_rd_ready), 32'd0);
            ar_wait++;
         end
         if (out_pix_valid) begin
            if (first_pv < 0) first_pv = cyc;
            if (tog && !in_pix_ready && !bp_checked) begin
               chk("rd_ready_while_full", 32'(out_rd_ready), 32'd0);
               bp_checked = 1;
            end
            if (in_pix_ready) begin
               wa = exp_ar(fr, y, words / 512) + 32'((words % 512) * 4);
               chk("pix_data", out_pix_data, gen(wa));
               chk("pix_last", 32'(out_pix_last), 32'(words == exp_w - 1));
               words++;
               last_pop = cyc;
            end
         end else if (timing && first_pv >= 0 && words < exp_w) begin
            gaps++;
         end
         if (out_req_ready) begin
            done = 1;
            rise = cyc;
         end
         cyc++;
         @(negedge axi_clk);
      end
      in_rd_valid = 1'b0; in_rd_last = 1'b0; in_rd_aready = 1'b0;
      chk("line_done", 32'(done), 32'd1);
      chk("word_count", 32'(words), 32'(exp_w));
      chk("burst_count", 32'(bursts), 32'(exp_b));
      chk("beat_count", 32'(beats), (last_at == 31) ? 32'(exp_b * 32) : 32'(last_at + 1));
      chk("err_pulses", 32'(errs), (last_at == 31) ? 32'd0 : 32'd1);
      if (timing) begin
         chk("r_to_pix_latency", 32'(first_pv - first_rhs), 32'd1);
         chk("pix_bubbles", 32'(gaps), 32'd0);
         chk("req_ready_rise", 32'(rise - last_pop), 32'd1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge axi_clk);
      chk("reset_avalid",    32'(out_rd_avalid), 32'd0);
      chk("reset_addr",      out_rd_addr,        32'd0);
      chk("reset_rd_ready",  32'(out_rd_ready),  32'd0);
      chk("reset_pix_valid", 32'(out_pix_valid), 32'd0);
      chk("reset_pix_last",  32'(out_pix_last),  32'd0);
      chk("reset_err",       32'(out_err),       32'd0);
      rst = 1'b0;
      @(negedge axi_clk);
      chk("req_ready_after_rst", 32'(out_req_ready), 32'd1);
      chk("rd_len", 32'(out_rd_len), 32'd31);

      // Full 2048-pixel line, single burst, no backpressure
      run_line(12'd2048, 12'd5, 3'd2, 0, 31, 1'b0, -1, 1'b1, ar0);
      chk("t1_first_ar", ar0, 32'h0200_5000);

      // Two bursts, line ends inside the second one
      run_line(12'd3000, 12'd0, 3'd0, 0, 31, 1'b0, -1, 1'b0, ar0);
      chk("t2_first_ar", ar0, 32'h0000_0000);

      // Short line with toggling downstream ready
      run_line(12'd64, 12'd33, 3'd1, 0, 31, 1'b1, -1, 1'b0, ar0);

      // AR ready delayed by 7 cycles
      run_line(12'd64, 12'd7, 3'd5, 7, 31, 1'b0, -1, 1'b0, ar0);
      chk("t4_first_ar", ar0, 32'h0500_7000);

      // Early last on beat 20, then a normal request
      run_line(12'd64, 12'd100, 3'd6, 0, 20, 1'b0, -1, 1'b0, ar0);
      run_line(12'd128, 12'd1, 3'd1, 0, 31, 1'b0, -1, 1'b0, ar0);

      // Reset during beat 10, then a fresh request
      run_line(12'd2048, 12'd11, 3'd4, 0, 31, 1'b0, 10, 1'b0, ar0);
      chk("req_ready_after_midrst", 32'(out_req_ready), 32'd1);
      run_line(12'd128, 12'd9, 3'd3, 0, 31, 1'b0, -1, 1'b0, ar0);
      chk("t6_first_ar", ar0, 32'h0300_9000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
